// File: rtl/slurm16_dma_pkg.sv
// -----------------------------------------------------------------------------
// slurm16_dma_pkg
//   Shared definitions for the slurm16 word-copy DMA engine: FSM state
//   encoding, register offsets on the peripheral bus, and bit positions within
//   the CTRL register for writes (commands) and reads (status).
// -----------------------------------------------------------------------------
package slurm16_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD      = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_WR      = 2'd3
  } dma_state_e;

  // Register offsets (reg_addr)
  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_LEN  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  // CTRL write bits
  localparam int CTRL_START    = 0;
  localparam int CTRL_IRQ_EN   = 1;
  localparam int CTRL_ABORT    = 2;
  localparam int CTRL_DONE_ACK = 3;

  // CTRL read bits
  localparam int STAT_BUSY   = 0;
  localparam int STAT_IRQ_EN = 1;
  localparam int STAT_DONE   = 2;

endpackage

// File: rtl/slurm16_dma_memcpy.sv
// -----------------------------------------------------------------------------
// slurm16_dma_memcpy
//   Word-copy DMA engine. Software programs SRC, DST and LEN, then writes
//   CTRL.start; the engine copies LEN words in ascending address order, one
//   read followed by one write per word, through a request/grant master port
//   on the memory arbiter. Completion sets a sticky done flag which, when
//   irq_en is set, raises a level interrupt.
//
// Ports
//   CLK, RSTb           clock, asynchronous active-low reset
//   reg_addr/reg_wr/    peripheral register write port (0 SRC, 1 DST,
//   reg_data_in         2 LEN, 3 CTRL)
//   reg_data_out        combinational register read data for reg_addr
//   mem_addr            word address of the current request
//   mem_rd_req          read request, held until mem_grant
//   mem_wr_req          write request, held until mem_grant
//   mem_wdata           write data, stable while mem_wr_req
//   mem_rdata           read data, valid the cycle after a read grant
//   mem_grant           arbiter accepts the current request this cycle
//   irq                 done & irq_en, registered
// -----------------------------------------------------------------------------
module slurm16_dma_memcpy
  import slurm16_dma_pkg::*;
#(
  parameter int ADDR_BITS = 16,
  parameter int DATA_BITS = 16
) (
  input  logic                 CLK,
  input  logic                 RSTb,
  input  logic [1:0]           reg_addr,
  input  logic                 reg_wr,
  input  logic [DATA_BITS-1:0] reg_data_in,
  output logic [DATA_BITS-1:0] reg_data_out,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_rd_req,
  output logic                 mem_wr_req,
  output logic [DATA_BITS-1:0] mem_wdata,
  input  logic [DATA_BITS-1:0] mem_rdata,
  input  logic                 mem_grant,
  output logic                 irq
);

  dma_state_e           state_q,  state_d;
  logic [ADDR_BITS-1:0] src_q,    src_d;
  logic [ADDR_BITS-1:0] dst_q,    dst_d;
  logic [ADDR_BITS-1:0] len_q,    len_d;
  logic [DATA_BITS-1:0] buf_q,    buf_d;
  logic                 irq_en_q, irq_en_d;
  logic                 done_q,   done_d;
  logic                 irq_q,    irq_d;

  logic busy;
  logic ctrl_wr;
  logic cmd_abort;
  logic cmd_start;
  logic cmd_done_ack;

  assign busy = (state_q != ST_IDLE);

  // ---------------------------------------------------------------------------
  // Next-state logic: register file, FSM and address counters
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave it unassigned and infer a latch.
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    buf_d    = buf_q;
    irq_en_d = irq_en_q;
    done_d   = done_q;

    ctrl_wr      = reg_wr && (reg_addr == REG_CTRL);
    cmd_abort    = ctrl_wr && reg_data_in[CTRL_ABORT];
    cmd_done_ack = ctrl_wr && reg_data_in[CTRL_DONE_ACK];
    // Abort wins over start in the same write; start is ignored while busy.
    cmd_start    = ctrl_wr && reg_data_in[CTRL_START] && !cmd_abort && !busy;

    if (ctrl_wr) begin
      irq_en_d = reg_data_in[CTRL_IRQ_EN];
    end
    if (cmd_done_ack) begin
      done_d = 1'b0;
    end

    // Address/length registers are frozen while a copy is running.
    if (reg_wr && !busy) begin
      unique case (reg_addr)
        REG_SRC: src_d = ADDR_BITS'(reg_data_in);
        REG_DST: dst_d = ADDR_BITS'(reg_data_in);
        REG_LEN: len_d = ADDR_BITS'(reg_data_in);
        default: ;
      endcase
    end

    // Completion assignments below come after done_ack so completion wins.
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_start) begin
          if (len_q == '0) begin
            done_d = 1'b1;
          end else begin
            done_d  = 1'b0;
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        if (mem_grant) state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        buf_d   = mem_rdata;
        state_d = ST_WR;
      end
      ST_WR: begin
        if (mem_grant) begin
          // Counters wrap naturally at 2^ADDR_BITS.
          src_d = src_q + 1'b1;
          dst_d = dst_q + 1'b1;
          len_d = len_q - 1'b1;
          if (len_q == ADDR_BITS'(1)) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RD;
          end
        end
      end
    endcase

    // A write granted in the abort cycle has reached memory, so the counters
    // keep that progress; only the done flag is held at its prior value.
    if (cmd_abort) begin
      state_d = ST_IDLE;
      done_d  = done_q && !cmd_done_ack;
    end

    irq_d = done_q && irq_en_q;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      state_q  <= ST_IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      buf_q    <= '0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // values, independent of statement order.
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      buf_q    <= buf_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
      irq_q    <= irq_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Memory port: decoded purely from registers, so requests, address and data
  // cannot glitch with inputs and drop immediately on reset.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_rd_req = (state_q == ST_RD);
    mem_wr_req = (state_q == ST_WR);
    mem_addr   = '0;
    mem_wdata  = '0;
    if (state_q == ST_RD) begin
      mem_addr = src_q;
    end else if (state_q == ST_WR) begin
      mem_addr  = dst_q;
      mem_wdata = buf_q;
    end
  end

  assign irq = irq_q;

  // ---------------------------------------------------------------------------
  // Register read-back (live values while busy)
  // ---------------------------------------------------------------------------
  always_comb begin
    reg_data_out = '0;
    unique case (reg_addr)
      REG_SRC: reg_data_out = DATA_BITS'(src_q);
      REG_DST: reg_data_out = DATA_BITS'(dst_q);
      REG_LEN: reg_data_out = DATA_BITS'(len_q);
      REG_CTRL: begin
        reg_data_out[STAT_BUSY]   = busy;
        reg_data_out[STAT_IRQ_EN] = irq_en_q;
        reg_data_out[STAT_DONE]   = done_q;
      end
    endcase
  end

endmodule

// File: tb/tb_slurm16_dma_memcpy.sv
// -----------------------------------------------------------------------------
// tb_slurm16_dma_memcpy
//   Directed bench for the slurm16 DMA copy engine. A bench-side RAM and
//   arbiter answer the master port with a programmable grant stall. A
//   transfer model expands each programmed copy into the ordered list of
//   memory operations it must produce (ascending read/write pairs, wrapping
//   addresses); a compare process matches every granted request against that
//   list and checks that ungranted requests stay stable. Literal expectations
//   pin register values, latency and RAM contents.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_slurm16_dma_memcpy;

  localparam logic [1:0] A_SRC  = 2'd0;
  localparam logic [1:0] A_DST  = 2'd1;
  localparam logic [1:0] A_LEN  = 2'd2;
  localparam logic [1:0] A_CTRL = 2'd3;

  logic        CLK;
  logic        RSTb;
  logic [1:0]  reg_addr;
  logic        reg_wr;
  logic [15:0] reg_data_in;
  logic [15:0] reg_data_out;
  logic [15:0] mem_addr;
  logic        mem_rd_req;
  logic        mem_wr_req;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_grant;
  logic        irq;

  slurm16_dma_memcpy #(.ADDR_BITS(16), .DATA_BITS(16)) dut (
    .CLK          (CLK),
    .RSTb         (RSTb),
    .reg_addr     (reg_addr),
    .reg_wr       (reg_wr),
    .reg_data_in  (reg_data_in),
    .reg_data_out (reg_data_out),
    .mem_addr     (mem_addr),
    .mem_rd_req   (mem_rd_req),
    .mem_wr_req   (mem_wr_req),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_grant    (mem_grant),
    .irq          (irq)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [15:0] data;
  } op_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  op_t         exp_q[$];
  logic [15:0] rd_log[$];
  logic [15:0] ram    [0:65535];
  logic [15:0] shadow [0:65535];
  logic [15:0] rdata_pending;
  int          stall      = 0;
  int          req_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  function automatic logic [15:0] init_word(input logic [15:0] a);
    return a ^ 16'hA5A5;
  endfunction

  // Expected operation stream for copying len words src->dst, ascending,
  // addresses modulo 2^16, reads seeing earlier writes of the same copy.
  task automatic model_copy(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len);
    logic [15:0] ov [logic [15:0]];
    for (int i = 0; i < int'(len); i++) begin
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] d;
      a = src + 16'(i);
      b = dst + 16'(i);
      d = ov.exists(a) ? ov[a] : shadow[a];
      exp_q.push_back('{wr: 1'b0, addr: a, data: 16'h0000});
      exp_q.push_back('{wr: 1'b1, addr: b, data: d});
      ov[b] = d;
    end
  endtask

  // ---------------------------------------------------------------------------
  // RAM + compare process, sampling on the falling edge
  // ---------------------------------------------------------------------------
  initial begin : mem_agent
    logic        held;
    logic        p_rd;
    logic        p_wr;
    logic [15:0] p_addr;
    logic [15:0] p_wdata;
    op_t         e;
    held = 1'b0;
    p_rd = 1'b0; p_wr = 1'b0; p_addr = '0; p_wdata = '0;
    rdata_pending = '0;
    for (int i = 0; i < 65536; i++) begin
      ram[i]    = init_word(16'(i));
      shadow[i] = ram[i];
    end
    forever begin
      @(negedge CLK);
      if (!RSTb) begin
        held = 1'b0;
      end else begin
        check("req_exclusive", 32'(mem_rd_req & mem_wr_req), 32'd0);
        if (held) begin
          check("held_kind", 32'({mem_rd_req, mem_wr_req}), 32'({p_rd, p_wr}));
          check("held_addr", 32'(mem_addr), 32'(p_addr));
          if (p_wr) check("held_wdata", 32'(mem_wdata), 32'(p_wdata));
        end
        if (mem_rd_req || mem_wr_req) req_cycles++;
        if (mem_grant && (mem_rd_req || mem_wr_req)) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_request: got request at 0x%0h, want none (t=%0t)",
                     mem_addr, $time);
          end else begin
            e = exp_q.pop_front();
            check("op_is_write", 32'(mem_wr_req), 32'(e.wr));
            check("op_addr", 32'(mem_addr), 32'(e.addr));
            if (e.wr) begin
              check("op_wdata", 32'(mem_wdata), 32'(e.data));
              shadow[e.addr] = e.data;
            end
          end
          if (mem_rd_req) begin
            rdata_pending = ram[mem_addr];
            rd_log.push_back(mem_addr);
          end else begin
            ram[mem_addr] = mem_wdata;
          end
        end
        held    = (mem_rd_req || mem_wr_req) && !mem_grant;
        p_rd    = mem_rd_req;
        p_wr    = mem_wr_req;
        p_addr  = mem_addr;
        p_wdata = mem_wdata;
      end
    end
  end

  // Arbiter: grants a request after it has waited 'stall' cycles.
  initial begin : grant_gen
    int wait_cnt;
    wait_cnt  = 0;
    mem_grant = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge CLK);
      #1;
      mem_rdata = rdata_pending;
      if (!RSTb || !(mem_rd_req || mem_wr_req)) begin
        mem_grant = 1'b0;
        wait_cnt  = 0;
      end else if (wait_cnt >= stall) begin
        mem_grant = 1'b1;
        wait_cnt  = 0;
      end else begin
        mem_grant = 1'b0;
        wait_cnt++;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Bus helpers
  // ---------------------------------------------------------------------------
  task automatic reg_write(input logic [1:0] a, input logic [15:0] d);
    @(posedge CLK); #1;
    reg_addr    = a;
    reg_data_in = d;
    reg_wr      = 1'b1;
    @(posedge CLK); #1;
    reg_wr      = 1'b0;
  endtask

  task automatic expect_reg(input string name, input logic [1:0] a, input logic [15:0] exp);
    reg_addr = a;
    #1;
    check(name, 32'(reg_data_out), 32'(exp));
  endtask

  // Counts rising edges until busy clears; returns just after a falling edge.
  task automatic wait_idle(input string name, input int budget, output int cycles);
    cycles = 0;
    forever begin
      @(posedge CLK);
      cycles++;
      @(negedge CLK);
      reg_addr = A_CTRL;
      #1;
      if (!reg_data_out[0]) break;
      if (cycles >= budget) begin
        flag_fail(name);
        break;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed tests
  // ---------------------------------------------------------------------------
  initial begin : main
    int          cyc;
    int          snap;
    logic        found;
    RSTb        = 1'b1;
    reg_addr    = A_SRC;
    reg_wr      = 1'b0;
    reg_data_in = '0;
    #2 RSTb = 1'b0;
    #1;
    check("rst_rd_req", 32'(mem_rd_req), 32'd0);
    check("rst_wr_req", 32'(mem_wr_req), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_reg0", 32'(reg_data_out), 32'd0);
    repeat (3) @(negedge CLK);
    #2 RSTb = 1'b1;

    // ---- 1: basic 4-word copy, grant always 1 ------------------------------
    stall = 0;
    reg_write(A_SRC, 16'h0100);
    reg_write(A_DST, 16'h0200);
    reg_write(A_LEN, 16'd4);
    model_copy(16'h0100, 16'h0200, 16'd4);
    @(posedge CLK); #1;
    reg_addr = A_CTRL; reg_data_in = 16'h0001; reg_wr = 1'b1;
    @(negedge CLK);
    check("t1_no_req_in_start_cycle", 32'(mem_rd_req), 32'd0);
    @(posedge CLK); #1;
    reg_wr = 1'b0;
    @(negedge CLK);
    check("t1_rd_req_next_cycle", 32'(mem_rd_req), 32'd1);
    check("t1_first_addr", 32'(mem_addr), 32'h0100);
    wait_idle("t1_wait_done", 100, cyc);
    check("t1_latency", 32'(cyc), 32'(3 * 4));
    expect_reg("t1_src", A_SRC, 16'h0104);
    expect_reg("t1_dst", A_DST, 16'h0204);
    expect_reg("t1_len", A_LEN, 16'h0000);
    @(negedge CLK);
    expect_reg("t1_ctrl", A_CTRL, 16'h0004);
    check("t1_irq_off", 32'(irq), 32'd0);
    check("t1_ops_left", 32'(exp_q.size()), 32'd0);
    check("t1_ram200", 32'(ram[16'h0200]), 32'hA4A5);
    check("t1_ram201", 32'(ram[16'h0201]), 32'hA4A4);
    check("t1_ram202", 32'(ram[16'h0202]), 32'hA4A7);
    check("t1_ram203", 32'(ram[16'h0203]), 32'hA4A6);

    // ---- 2: LEN=0 start, done/irq behaviour ---------------------------------
    snap = req_cycles;
    reg_write(A_CTRL, 16'h0008);
    expect_reg("t2_ack_clears", A_CTRL, 16'h0000);
    reg_write(A_LEN, 16'h0000);
    reg_write(A_CTRL, 16'h0001);
    @(negedge CLK);
    expect_reg("t2_done_noirq", A_CTRL, 16'h0004);
    check("t2_irq_disabled", 32'(irq), 32'd0);
    @(negedge CLK);
    check("t2_irq_still_disabled", 32'(irq), 32'd0);
    reg_write(A_CTRL, 16'h0008);
    expect_reg("t2_ack2", A_CTRL, 16'h0000);
    reg_write(A_CTRL, 16'h0003);
    @(negedge CLK);
    expect_reg("t2_done_irqen", A_CTRL, 16'h0006);
    check("t2_irq_lag", 32'(irq), 32'd0);
    @(negedge CLK);
    check("t2_irq_set", 32'(irq), 32'd1);
    reg_write(A_CTRL, 16'h000B);
    @(negedge CLK);
    expect_reg("t2_completion_beats_ack", A_CTRL, 16'h0006);
    check("t2_irq_held", 32'(irq), 32'd1);
    reg_write(A_CTRL, 16'h000A);
    @(negedge CLK);
    expect_reg("t2_ack_keeps_en", A_CTRL, 16'h0002);
    check("t2_irq_lag_drop", 32'(irq), 32'd1);
    @(negedge CLK);
    check("t2_irq_dropped", 32'(irq), 32'd0);
    reg_write(A_CTRL, 16'h0000);
    check("t2_no_requests", 32'(req_cycles), 32'(snap));

    // ---- 3: stalled grants ---------------------------------------------------
    stall = 5;
    reg_write(A_SRC, 16'h0100);
    reg_write(A_DST, 16'h0600);
    reg_write(A_LEN, 16'd3);
    model_copy(16'h0100, 16'h0600, 16'd3);
    reg_write(A_CTRL, 16'h0001);
    wait_idle("t3_wait_done", 200, cyc);
    check("t3_latency", 32'(cyc), 32'(3 * (3 + 2 * 5)));
    check("t3_ops_left", 32'(exp_q.size()), 32'd0);
    check("t3_ram600", 32'(ram[16'h0600]), 32'hA4A5);
    check("t3_ram601", 32'(ram[16'h0601]), 32'hA4A4);
    check("t3_ram602", 32'(ram[16'h0602]), 32'hA4A7);
    expect_reg("t3_src", A_SRC, 16'h0103);

    // ---- 4: source address wrap ---------------------------------------------
    stall = 0;
    rd_log.delete();
    reg_write(A_SRC, 16'hFFFE);
    reg_write(A_DST, 16'h0500);
    reg_write(A_LEN, 16'd3);
    model_copy(16'hFFFE, 16'h0500, 16'd3);
    reg_write(A_CTRL, 16'h0001);
    wait_idle("t4_wait_done", 50, cyc);
    check("t4_latency", 32'(cyc), 32'd9);
    check("t4_nreads", 32'(rd_log.size()), 32'd3);
    if (rd_log.size() == 3) begin
      check("t4_rd0", 32'(rd_log[0]), 32'hFFFE);
      check("t4_rd1", 32'(rd_log[1]), 32'hFFFF);
      check("t4_rd2", 32'(rd_log[2]), 32'h0000);
    end
    expect_reg("t4_src_wrapped", A_SRC, 16'h0001);
    check("t4_ram500", 32'(ram[16'h0500]), 32'h5A5B);
    check("t4_ram501", 32'(ram[16'h0501]), 32'h5A5A);
    check("t4_ram502", 32'(ram[16'h0502]), 32'hA5A5);

    // ---- 5: abort after 2 of 8 words ----------------------------------------
    reg_write(A_CTRL, 16'h0008);
    reg_write(A_SRC, 16'h0300);
    reg_write(A_DST, 16'h0900);
    reg_write(A_LEN, 16'd8);
    model_copy(16'h0300, 16'h0900, 16'd8);
    reg_write(A_CTRL, 16'h0001);
    reg_write(A_SRC, 16'h1234);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge CLK);
      reg_addr = A_LEN;
      #1;
      if (reg_data_out == 16'd6) found = 1'b1;
    end
    if (!found) flag_fail("t5_wait_two_words");
    reg_write(A_CTRL, 16'h0004);
    @(negedge CLK);
    expect_reg("t5_idle_not_done", A_CTRL, 16'h0000);
    expect_reg("t5_len", A_LEN, 16'd6);
    expect_reg("t5_src", A_SRC, 16'h0302);
    @(negedge CLK);
    expect_reg("t5_dst", A_DST, 16'h0902);
    check("t5_ops_left", 32'(exp_q.size()), 32'd11);
    check("t5_ram900", 32'(ram[16'h0900]), 32'hA6A5);
    check("t5_ram901", 32'(ram[16'h0901]), 32'hA6A4);
    check("t5_ram902_untouched", 32'(ram[16'h0902]), 32'hACA7);
    exp_q.delete();
    snap = req_cycles;
    repeat (4) @(negedge CLK);
    check("t5_quiet_after_abort", 32'(req_cycles), 32'(snap));

    // ---- 6: reset during a pending write ------------------------------------
    stall = 5;
    reg_write(A_SRC, 16'h0700);
    reg_write(A_DST, 16'h0800);
    reg_write(A_LEN, 16'd2);
    model_copy(16'h0700, 16'h0800, 16'd2);
    reg_write(A_CTRL, 16'h0003);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge CLK);
      if (mem_wr_req) found = 1'b1;
    end
    if (!found) flag_fail("t6_wait_write");
    #2 RSTb = 1'b0;
    #1;
    check("t6_rd_req", 32'(mem_rd_req), 32'd0);
    check("t6_wr_req", 32'(mem_wr_req), 32'd0);
    check("t6_addr", 32'(mem_addr), 32'd0);
    check("t6_irq", 32'(irq), 32'd0);
    expect_reg("t6_src", A_SRC, 16'h0000);
    expect_reg("t6_dst", A_DST, 16'h0000);
    expect_reg("t6_len", A_LEN, 16'h0000);
    expect_reg("t6_ctrl", A_CTRL, 16'h0000);
    exp_q.delete();
    @(negedge CLK);
    #2 RSTb = 1'b1;
    snap = req_cycles;
    repeat (4) @(negedge CLK);
    check("t6_quiet_after_reset", 32'(req_cycles), 32'(snap));
    check("t6_ram800_unwritten", 32'(ram[16'h0800]), 32'hADA5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
